// File: rtl/ila_capture.sv
// Logic analyser core: circular sample buffer with pre/post-trigger capture,
// pattern/edge/external trigger, decimation and word-sliced bus readback.
module ila_capture #(
  parameter int          WIDTH     = 32,
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             trigger_in,
  input  logic [WIDTH-1:0] sample_in,
  output logic             trig_out,
  output logic             armed,
  input  logic [31:0]      bus_addr,
  input  logic             bus_wen,
  input  logic             bus_ren,
  input  logic [31:0]      bus_wdata,
  output logic [31:0]      bus_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int NW = (WIDTH + 31) / 32;
  localparam int PW = 32 * NW;
  localparam int MW = (WIDTH < 32) ? WIDTH : 32;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_ARMED = 2'd1, S_POST = 2'd2, S_DONE = 2'd3} state_t;

  state_t           r_state;
  logic [31:0]      r_post, r_mask, r_value, r_wsel;
  logic [4:0]       r_mode;
  logic [15:0]      r_decim, r_dec_cnt;
  logic [AW-1:0]    r_wr_ptr, r_trig_addr, r_post_cnt;
  logic             r_wrapped, r_trig_ok, r_prev_match, r_trig_out, r_rd_zero;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rd_sample;

  logic [31:0]   w_off, w_ram_off, w_s32, w_reg_data, w_word;
  logic          w_reg_hit, w_ram_hit, w_ctrl_wr, w_arm, w_abort, w_run, w_tick;
  logic          w_match, w_base, w_hit, w_wr_en, w_idx_ok;
  logic [AW-1:0] w_idx, w_phys, w_tpos, w_post_ld;
  logic [11:0]   w_vc;
  logic [PW-1:0] w_pad;

  assign w_off     = bus_addr - BASE_ADDR;
  assign w_ram_off = w_off - 32'h1000;
  assign w_reg_hit = (w_off[31:5] == 27'd0) && (w_off[1:0] == 2'd0);
  assign w_ram_hit = (w_off >= 32'h1000) && ({2'b00, w_ram_off[31:2]} < 32'(DEPTH))
                     && (w_ram_off[1:0] == 2'd0);
  assign w_idx     = w_ram_off[AW+1:2];

  assign w_ctrl_wr = bus_wen && w_reg_hit && (w_off[4:2] == 3'd1);
  assign w_arm     = w_ctrl_wr && bus_wdata[0];
  assign w_abort   = w_ctrl_wr && bus_wdata[1];
  assign w_run     = (r_state == S_ARMED) || (r_state == S_POST);
  assign w_tick    = w_run && (r_dec_cnt == 16'd0);
  assign w_wr_en   = w_tick && !w_arm && !w_abort && !rst;

  assign w_s32   = 32'(sample_in[MW-1:0]);
  assign w_match = ((w_s32 & r_mask) == (r_value & r_mask));

  always_comb begin
    w_base = 1'b0;
    case (r_mode[1:0])
      2'd0: w_base = trigger_in;
      2'd1: w_base = w_match;
      2'd2: w_base = w_match && !r_prev_match;
      2'd3: w_base = 1'b1;
      default: w_base = 1'b0;
    endcase
  end

  // A CTRL write in the same cycle masks the trigger so software always wins.
  assign w_hit = w_tick && (r_state == S_ARMED) && !w_ctrl_wr && w_base
                 && (!r_mode[4] || trigger_in);
  // Keep the trigger sample from being overwritten by its own post-capture.
  assign w_post_ld = (r_post >= 32'(DEPTH - 1)) ? AW'(DEPTH - 1) : r_post[AW-1:0];

  assign w_vc     = r_wrapped ? 12'(DEPTH) : 12'(r_wr_ptr);
  assign w_tpos   = r_wrapped ? (r_trig_addr - r_wr_ptr) : r_trig_addr;
  assign w_phys   = r_wrapped ? (r_wr_ptr + w_idx) : w_idx;
  assign w_idx_ok = r_wrapped || (w_idx < r_wr_ptr);

  assign armed    = w_run;
  assign trig_out = r_trig_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_post <= '0; r_mask <= '0; r_value <= '0; r_wsel <= '0; r_mode <= '0; r_decim <= '0;
      r_dec_cnt <= '0; r_wr_ptr <= '0; r_trig_addr <= '0; r_post_cnt <= '0;
      r_wrapped <= 1'b0; r_trig_ok <= 1'b0; r_prev_match <= 1'b0; r_trig_out <= 1'b0;
      r_rd_zero <= 1'b1;
    end else begin
      r_trig_out <= w_hit;
      r_rd_zero  <= !(bus_ren && w_ram_hit && w_idx_ok && !w_run);
      if (bus_wen && w_reg_hit) begin
        case (w_off[4:2])
          3'd2: r_post  <= bus_wdata;
          3'd3: r_mode  <= bus_wdata[4:0];
          3'd4: r_mask  <= bus_wdata;
          3'd5: r_value <= bus_wdata;
          3'd6: r_decim <= bus_wdata[15:0];
          3'd7: r_wsel  <= bus_wdata;
          default: ;
        endcase
      end
      if (w_abort) begin
        r_state <= S_DONE;
      end else if (w_arm) begin
        r_state      <= S_ARMED;
        r_wr_ptr     <= '0;
        r_wrapped    <= 1'b0;
        r_trig_ok    <= 1'b0;
        r_dec_cnt    <= '0;
        r_prev_match <= 1'b0;
      end else begin
        r_dec_cnt <= (r_dec_cnt == 16'd0) ? r_decim : r_dec_cnt - 16'd1;
        if (w_tick) begin
          r_wr_ptr     <= r_wr_ptr + AW'(1);
          r_prev_match <= w_match;
          if (r_wr_ptr == AW'(DEPTH - 1)) r_wrapped <= 1'b1;
          if (r_state == S_ARMED && w_hit) begin
            r_trig_addr <= r_wr_ptr;
            r_trig_ok   <= 1'b1;
            r_post_cnt  <= w_post_ld;
            r_state     <= (w_post_ld == '0) ? S_DONE : S_POST;
          end else if (r_state == S_POST) begin
            r_post_cnt <= r_post_cnt - AW'(1);
            if (r_post_cnt == AW'(1)) r_state <= S_DONE;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= sample_in;
    r_rd_sample <= r_mem[w_phys];
  end

  assign w_pad = PW'(r_rd_sample);

  always_comb begin
    w_word = '0;
    for (int k = 0; k < NW; k++)
      if (r_wsel == 32'(k)) w_word = w_pad[32*k +: 32];
  end

  always_comb begin
    w_reg_data = '0;
    case (w_off[4:2])
      3'd0: w_reg_data = {16'(DEPTH), 16'(WIDTH)};
      3'd1: w_reg_data = {16'(w_tpos), w_vc, r_trig_ok, r_wrapped, r_state};
      3'd2: w_reg_data = r_post;
      3'd3: w_reg_data = {27'd0, r_mode};
      3'd4: w_reg_data = r_mask;
      3'd5: w_reg_data = r_value;
      3'd6: w_reg_data = {16'd0, r_decim};
      3'd7: w_reg_data = r_wsel;
      default: w_reg_data = '0;
    endcase
  end

  assign bus_rdata = w_reg_hit ? w_reg_data :
                     (w_ram_hit && !r_rd_zero) ? w_word : 32'd0;
endmodule

// File: tb/tb_ila_capture.sv
// Directed bench for ila_capture: a 32-bit and a 72-bit instance on one bus,
// expected read data queued by the stimulus and checked by a monitor.
module tb_ila_capture;
  localparam logic [31:0] BB = 32'h2000_0000;

  typedef struct {
    string       name;
    logic [31:0] exp;
    logic [31:0] act;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1, trigger_in = 1'b0;
  logic [31:0] smp = '0;
  logic [71:0] smp_b;
  logic [31:0] bus_addr = '0, bus_wdata = '0;
  logic        bus_wen = 1'b0, bus_ren = 1'b0;
  logic [31:0] rdata_a, rdata_b, rdata;
  logic        trig_a, trig_b, armed_a, armed_b;

  exp_t q[$];
  exp_t dq[$];
  exp_t m_e;
  bit   tb_valid = 1'b0;
  int   checks = 0, errors = 0, trig_cnt = 0, tbase;

  always #5 clk = ~clk;

  assign smp_b = {smp[7:0], 32'h1234_5678, smp};
  assign rdata = bus_addr[29] ? rdata_b : rdata_a;

  ila_capture #(.WIDTH(32), .DEPTH(16), .BASE_ADDR(32'h0)) u_a (
    .clk(clk), .rst(rst), .trigger_in(trigger_in), .sample_in(smp),
    .trig_out(trig_a), .armed(armed_a), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_ren(bus_ren), .bus_wdata(bus_wdata), .bus_rdata(rdata_a));

  ila_capture #(.WIDTH(72), .DEPTH(16), .BASE_ADDR(BB)) u_b (
    .clk(clk), .rst(rst), .trigger_in(trigger_in), .sample_in(smp_b),
    .trig_out(trig_b), .armed(armed_b), .bus_addr(bus_addr), .bus_wen(bus_wen),
    .bus_ren(bus_ren), .bus_wdata(bus_wdata), .bus_rdata(rdata_b));

  function automatic void chk(string n, logic [31:0] act, logic [31:0] e);
    checks++;
    if (act !== e) begin
      errors++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", n, act, e);
    end
  endfunction

  // Monitor: bus reads are compared while the stimulus flags them presented.
  always @(negedge clk) begin
    if (tb_valid) begin
      if (q.size() == 0) chk("scoreboard_empty", 32'd1, 32'd0);
      else begin
        m_e = q.pop_front();
        chk(m_e.name, rdata, m_e.exp);
      end
    end
    while (dq.size() != 0) begin
      m_e = dq.pop_front();
      chk(m_e.name, m_e.act, m_e.exp);
    end
  end

  always @(negedge clk) if (trig_a) trig_cnt <= trig_cnt + 1;

  task automatic step();
    @(posedge clk); #1;
    smp = smp + 32'd1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus_addr = a; bus_wdata = d; bus_wen = 1'b1;
    step();
    bus_wen = 1'b0;
  endtask

  task automatic rd_reg(input string n, input logic [31:0] a, input logic [31:0] e);
    bus_addr = a; bus_ren = 1'b1;
    q.push_back('{name: n, exp: e, act: 32'd0});
    tb_valid = 1'b1;
    @(negedge clk); #1;
    tb_valid = 1'b0;
    step();
    bus_ren = 1'b0;
  endtask

  task automatic rd_ram(input string n, input logic [31:0] a, input logic [31:0] e);
    bus_addr = a; bus_ren = 1'b1;
    step();
    q.push_back('{name: n, exp: e, act: 32'd0});
    tb_valid = 1'b1;
    @(negedge clk); #1;
    tb_valid = 1'b0;
    step();
    bus_ren = 1'b0;
  endtask

  task automatic dchk(input string n, input logic [31:0] act, input logic [31:0] e);
    dq.push_back('{name: n, exp: e, act: act});
  endtask

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  initial begin
    step(); step();
    rst = 1'b0;
    rd_reg("rst_status", 32'h04, 32'h0);
    rd_reg("info_a", 32'h00, 32'h0010_0020);
    rd_reg("rst_post", 32'h08, 32'h0);
    rd_reg("unmapped", 32'h20, 32'h0);
    rd_reg("info_b", BB, 32'h0010_0048);
    dchk("rst_armed", 32'(armed_a), 32'd0);
    dchk("rst_trig_out", 32'(trig_a), 32'd0);

    // forced trigger, POST=4
    wr(32'h08, 4); wr(32'h0C, 3); wr(32'h18, 0);
    smp = 32'h100;
    wr(32'h04, 1);
    dchk("t1_armed", 32'(armed_a), 32'd1);
    repeat (4) step();
    rd_reg("t1_status_post", 32'h04, 32'h4A);
    rd_reg("t1_status_done", 32'h04, 32'h5B);
    rd_ram("t1_idx0", 32'h1000, 32'h101);
    rd_ram("t1_idx4", 32'h1010, 32'h105);
    rd_ram("t1_idx5_invalid", 32'h1014, 32'h0);

    // masked pattern match on a counter
    wr(32'h10, 32'hFF); wr(32'h14, 32'hAB42); wr(32'h0C, 1); wr(32'h08, 3);
    rd_reg("t2_mask_rb", 32'h10, 32'hFF);
    smp = 32'h3C;
    tbase = trig_cnt;
    wr(32'h04, 1);
    repeat (12) step();
    rd_reg("t2_status", 32'h04, 32'h0005_009B);
    rd_ram("t2_trig_sample", 32'h1014, 32'h42);
    rd_ram("t2_post1", 32'h1018, 32'h43);
    rd_ram("t2_post3", 32'h1020, 32'h45);
    dchk("t2_trig_pulses", 32'(trig_cnt - tbase), 32'd1);
    dchk("t2_armed_done", 32'(armed_a), 32'd0);

    // wrap with external trigger after 40 pre-trigger ticks
    wr(32'h0C, 0); wr(32'h08, 5);
    smp = 32'h200;
    wr(32'h04, 1);
    repeat (40) step();
    trigger_in = 1'b1;
    step();
    trigger_in = 1'b0;
    repeat (8) step();
    rd_reg("t3_status", 32'h04, 32'h000A_010F);
    rd_ram("t3_oldest", 32'h1000, 32'h21F);
    rd_ram("t3_trig", 32'h1028, 32'h229);
    rd_ram("t3_newest", 32'h103C, 32'h22E);

    // rising-edge trigger on a held level, decimation by 3
    wr(32'h10, 32'hF00); wr(32'h14, 32'h500); wr(32'h0C, 2); wr(32'h08, 3); wr(32'h18, 2);
    smp = 32'h510;
    tbase = trig_cnt;
    wr(32'h04, 1);
    repeat (14) step();
    rd_reg("t4_status", 32'h04, 32'h4B);
    rd_ram("t4_idx0", 32'h1000, 32'h511);
    rd_ram("t4_idx1", 32'h1004, 32'h514);
    rd_ram("t4_idx3", 32'h100C, 32'h51A);
    dchk("t4_trig_pulses", 32'(trig_cnt - tbase), 32'd1);
    wr(32'h18, 0);

    // CTRL write drops a coincident trigger; abort; arm+abort
    wr(32'h0C, 0);
    tbase = trig_cnt;
    wr(32'h04, 1);
    step(); step();
    trigger_in = 1'b1;
    wr(32'h04, 0);
    trigger_in = 1'b0;
    rd_reg("t5_trig_dropped", 32'h04, 32'h31);
    wr(32'h04, 2);
    rd_reg("t5_abort", 32'h04, 32'h43);
    dchk("t5_no_pulse", 32'(trig_cnt - tbase), 32'd0);
    wr(32'h04, 1);
    step();
    wr(32'h04, 3);
    rd_reg("t5_arm_abort", 32'h04, 32'h13);

    // 72-bit instance: word select, then reset during POST
    wr(BB + 32'h0C, 3); wr(BB + 32'h08, 2); wr(BB + 32'h1C, 2);
    smp = 32'h3F0;
    wr(BB + 32'h04, 1);
    repeat (5) step();
    rd_reg("t6_status", BB + 32'h04, 32'h3B);
    rd_ram("t6_w2_idx0", BB + 32'h1000, 32'hF1);
    rd_ram("t6_w2_idx1", BB + 32'h1004, 32'hF2);
    wr(BB + 32'h1C, 1);
    rd_ram("t6_w1_idx0", BB + 32'h1000, 32'h1234_5678);
    wr(BB + 32'h1C, 3);
    rd_ram("t6_w3_beyond", BB + 32'h1000, 32'h0);
    wr(BB + 32'h08, 10); wr(BB + 32'h1C, 0);
    wr(BB + 32'h04, 1);
    step(); step();
    rd_ram("t6_ram_in_post", BB + 32'h1000, 32'h0);
    dchk("t6_armed_post", 32'(armed_b), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_reg("t6_rst_status", BB + 32'h04, 32'h0);
    rd_reg("t6_rst_post", BB + 32'h08, 32'h0);
    rd_reg("t6_rst_mode", BB + 32'h0C, 32'h0);
    rd_reg("t6_rst_mask_a", 32'h10, 32'h0);
    dchk("t6_rst_armed", 32'(armed_b), 32'd0);

    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
